single_wire_reader: RTL and testbench



---
 rtl/single_wire_pkg.sv | 48 ++++
 rtl/single_wire_reader_if.sv | 26 ++
 rtl/single_wire_reader_line_synchronizer.sv | 35 +++
 rtl/single_wire_reader.sv | 182 ++++++++++++++++++
 tb/tb_single_wire_reader.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/single_wire_pkg.sv
// Shared types and frame helpers for the single-wire sensor reader.
package single_wire_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BIT_IDX_W  = 6;
  localparam int unsigned SUM_W      = BYTE_W + 2;

  localparam int unsigned BYTE_HUM_HI  = 0;
  localparam int unsigned BYTE_HUM_LO  = 1;
  localparam int unsigned BYTE_TEMP_HI = 2;
  localparam int unsigned BYTE_TEMP_LO = 3;
  localparam int unsigned BYTE_CSUM    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_RESP_TIMEOUT = 2'd1,
    ERR_BIT_TIMEOUT  = 2'd2,
    ERR_CHECKSUM     = 2'd3
  } err_code_e;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Byte 0 is the first byte on the wire (frame MSBs).
  function automatic logic [BYTE_W-1:0] frame_byte(frame_t f, int unsigned idx);
    return BYTE_W'(f >> (BYTE_W * (FRAME_BITS / BYTE_W - 1 - idx)));
  endfunction

  function automatic logic checksum_ok(frame_t f);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(frame_byte(f, BYTE_HUM_HI)) + SUM_W'(frame_byte(f, BYTE_HUM_LO))
        + SUM_W'(frame_byte(f, BYTE_TEMP_HI)) + SUM_W'(frame_byte(f, BYTE_TEMP_LO));
    return sum[BYTE_W-1:0] == frame_byte(f, BYTE_CSUM);
  endfunction

endpackage

// File: rtl/single_wire_reader_if.sv
// Pad-buffer and fan-control side signals of the single-wire reader.
interface single_wire_reader_if;
  import single_wire_pkg::*;

  logic              start;
  logic              line_in;
  logic              drive_en;
  logic              drive_data;
  logic              busy;
  logic              valid;
  logic [DATA_W-1:0] humidity;
  logic [DATA_W-1:0] temperature;
  logic              error;
  err_code_e         err_code;

  modport master (
    output start, line_in,
    input  drive_en, drive_data, busy, valid, humidity, temperature, error, err_code
  );

  modport slave (
    input  start, line_in,
    output drive_en, drive_data, busy, valid, humidity, temperature, error, err_code
  );

endinterface

// File: rtl/single_wire_reader_line_synchronizer.sv
// Two-flop synchronizer for the raw pad level with registered edge flags
// that line up with the cycle in which the synchronized level changes.
module single_wire_reader_line_synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic ls_o,
  output logic fall_o,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic fall_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      fall_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      fall_q <= s2_q & ~s1_q;
      rise_q <= ~s2_q & s1_q;
    end
  end

  assign ls_o   = s2_q;
  assign fall_o = fall_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/single_wire_reader.sv
// Host-side reader for a DHT-style single-wire sensor: start pulse,
// response timing, 40-bit pulse-width decode and checksum.
module single_wire_reader
  import single_wire_pkg::*;
#(
  parameter int unsigned START_LOW_CYCLES  = 1800000,
  parameter int unsigned BIT_THRESH_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES    = 20000,
  parameter int unsigned CNT_W             = 21
) (
  input logic                 clk,
  input logic                 rst_n,
  single_wire_reader_if.slave bus
);

  localparam logic [CNT_W-1:0]     START_LAST   = CNT_W'(START_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]     THRESH       = CNT_W'(BIT_THRESH_CYCLES);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT     = BIT_IDX_W'(FRAME_BITS - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_inc_c;
  logic [BIT_IDX_W-1:0] bit_idx_q;
  frame_t              shift_q;
  logic                drive_en_q;
  logic                busy_q;
  logic                valid_q;
  logic                error_q;
  err_code_e           err_code_q;
  logic [DATA_W-1:0]   humidity_q;
  logic [DATA_W-1:0]   temperature_q;
  logic                ls;
  logic                ls_fall;
  logic                ls_rise;
  logic                timeout_c;

  single_wire_reader_line_synchronizer u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (bus.line_in),
    .ls_o   (ls),
    .fall_o (ls_fall),
    .rise_o (ls_rise)
  );

  assign cnt_inc_c = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_c = (cnt_q >= TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      drive_en_q    <= 1'b0;
      busy_q        <= 1'b0;
      valid_q       <= 1'b0;
      error_q       <= 1'b0;
      err_code_q    <= ERR_NONE;
      humidity_q    <= '0;
      temperature_q <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= cnt_inc_c;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          // A start coinciding with the result pulse is dropped.
          if (bus.start && !valid_q && !error_q) begin
            state_q    <= S_START_LOW;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            err_code_q <= ERR_NONE;
            busy_q     <= 1'b1;
            drive_en_q <= 1'b1;
          end
        end
        S_START_LOW: begin
          if (cnt_q == START_LAST) begin
            state_q    <= S_WAIT_RESP;
            cnt_q      <= '0;
            drive_en_q <= 1'b0;
          end
        end
        // ls still shows the host's own low for a few cycles; wait for a real fall.
        S_WAIT_RESP: begin
          if (ls_fall) begin
            state_q <= S_RESP_LOW;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_RESP_TIMEOUT;
          end
        end
        S_RESP_LOW: begin
          if (ls) begin
            state_q <= S_RESP_HIGH;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_RESP_TIMEOUT;
          end
        end
        S_RESP_HIGH: begin
          if (!ls) begin
            state_q <= S_BIT_LOW;
            cnt_q   <= '0;
          end else if (timeout_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_RESP_TIMEOUT;
          end
        end
        S_BIT_LOW: begin
          if (ls_rise) begin
            // The rise cycle already belongs to the high pulse.
            state_q <= S_BIT_HIGH;
            cnt_q   <= CNT_W'(1);
          end else if (timeout_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_BIT_TIMEOUT;
          end
        end
        S_BIT_HIGH: begin
          if (ls_fall) begin
            shift_q   <= {shift_q[FRAME_BITS-2:0], (cnt_q > THRESH)};
            bit_idx_q <= bit_idx_q + BIT_IDX_W'(1);
            cnt_q     <= '0;
            state_q   <= (bit_idx_q == LAST_BIT) ? S_CHECK : S_BIT_LOW;
          end else if (timeout_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b1;
            err_code_q <= ERR_BIT_TIMEOUT;
          end
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          if (checksum_ok(shift_q)) begin
            humidity_q    <= {frame_byte(shift_q, BYTE_HUM_HI), frame_byte(shift_q, BYTE_HUM_LO)};
            temperature_q <= {frame_byte(shift_q, BYTE_TEMP_HI), frame_byte(shift_q, BYTE_TEMP_LO)};
            valid_q       <= 1'b1;
          end else begin
            error_q    <= 1'b1;
            err_code_q <= ERR_CHECKSUM;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          drive_en_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.drive_en    = drive_en_q;
  assign bus.drive_data  = 1'b0;
  assign bus.busy        = busy_q;
  assign bus.valid       = valid_q;
  assign bus.error       = error_q;
  assign bus.err_code    = err_code_q;
  assign bus.humidity    = humidity_q;
  assign bus.temperature = temperature_q;

endmodule

// File: tb/tb_single_wire_reader.sv
// Bench for single_wire_reader: behavioural sensor on a pulled-up line and a
// frame-level reference model of the expected read outcome.
module tb_single_wire_reader;
  import single_wire_pkg::*;

  localparam int START_N = 20;
  localparam int THRESH  = 10;
  localparam int TMO     = 60;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sensor_q = 1'b1;

  always #5 clk = ~clk;

  single_wire_reader_if bus ();

  // Pulled-up open-drain line: low if either side pulls it.
  assign bus.line_in = bus.drive_en ? 1'b0 : sensor_q;

  single_wire_reader #(
    .START_LOW_CYCLES  (START_N),
    .BIT_THRESH_CYCLES (THRESH),
    .TIMEOUT_CYCLES    (TMO),
    .CNT_W             (21)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Activity monitor, sampled on the inactive edge.
  int   cyc = 0;
  int   de_high = 0, valid_n = 0, error_n = 0, both_n = 0;
  int   de_fall_cyc = -1, err_cyc = -1;
  logic de_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus.drive_en === 1'b1) de_high++;
    if (de_prev === 1'b1 && bus.drive_en === 1'b0) de_fall_cyc = cyc;
    de_prev = bus.drive_en;
    if (bus.valid === 1'b1) valid_n++;
    if (bus.error === 1'b1) begin
      error_n++;
      err_cyc = cyc;
    end
    if (bus.valid === 1'b1 && bus.error === 1'b1) both_n++;
  end

  // Sensor stimulus description for one read.
  int   hi_len[40];
  int   lo_len[40];
  int   resp_low, resp_high;
  bit   no_resp, start_on_pulse;
  int   stuck_bit, mid_start_bit, reset_bit;
  logic [15:0] exp_hum = 16'h0;
  logic [15:0] exp_temp = 16'h0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_frame(input logic [39:0] f, input int zero_hi, input int one_hi);
    for (int b = 0; b < 40; b++) begin
      hi_len[b] = f[39-b] ? one_hi : zero_hi;
      lo_len[b] = 5;
    end
    resp_low = 8; resp_high = 8;
    no_resp = 0; start_on_pulse = 0;
    stuck_bit = -1; mid_start_bit = -1; reset_bit = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_drive_en"},    bus.drive_en,    0);
    check_eq({tag, "_drive_data"},  bus.drive_data,  0);
    check_eq({tag, "_busy"},        bus.busy,        0);
    check_eq({tag, "_valid"},       bus.valid,       0);
    check_eq({tag, "_error"},       bus.error,       0);
    check_eq({tag, "_err_code"},    bus.err_code,    0);
    check_eq({tag, "_humidity"},    bus.humidity,    0);
    check_eq({tag, "_temperature"}, bus.temperature, 0);
  endtask

  task automatic run_read(input string name);
    bit          got_pulse, was_reset;
    logic [39:0] dec;
    int          bytes[5];
    int          exp_err;
    was_reset = 0;
    @(negedge clk);
    de_high = 0; valid_n = 0; error_n = 0; both_n = 0; err_cyc = -1; de_fall_cyc = -1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200 && bus.drive_en === 1'b1; i++) @(negedge clk);

    if (!no_resp) begin
      tick(3);
      sensor_q = 1'b0; tick(resp_low);
      sensor_q = 1'b1; tick(resp_high);
      for (int b = 0; b < 40; b++) begin
        sensor_q = 1'b0; tick(lo_len[b]);
        sensor_q = 1'b1;
        if (b == stuck_bit) break;
        if (b == reset_bit) begin
          tick(4);
          rst_n = 1'b0;
          @(negedge clk);
          check_reset_outputs({name, "_midreset"});
          rst_n = 1'b1;
          was_reset = 1;
          break;
        end
        if (b == mid_start_bit) begin
          bus.start = 1'b1;
          @(negedge clk);
          bus.start = 1'b0;
          check_eq({name, "_midstart_busy"}, bus.busy, 1);
          tick(hi_len[b] - 1);
        end else begin
          tick(hi_len[b]);
        end
      end
      if (stuck_bit < 0 && !was_reset) sensor_q = 1'b0;
    end

    if (was_reset) begin
      tick(5);
      exp_hum = 16'h0; exp_temp = 16'h0;
      check_eq({name, "_no_valid"}, valid_n, 0);
      check_eq({name, "_no_error"}, error_n, 0);
      check_eq({name, "_idle_busy"}, bus.busy, 0);
      return;
    end

    got_pulse = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.valid === 1'b1 || bus.error === 1'b1) begin
        got_pulse = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq({name, "_pulse_seen"}, got_pulse, 1);
    if (start_on_pulse) begin
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      tick(1);
      check_eq({name, "_start_on_pulse_drive_en"}, bus.drive_en, 0);
      check_eq({name, "_start_on_pulse_busy"}, bus.busy, 0);
    end
    sensor_q = 1'b1;
    tick(4);

    // Reference model: decode by pulse width, then the checksum rule.
    if (no_resp) begin
      exp_err = 1;
    end else if (stuck_bit >= 0) begin
      exp_err = 2;
    end else begin
      for (int b = 0; b < 40; b++) dec[39-b] = (hi_len[b] > THRESH);
      for (int k = 0; k < 5; k++) bytes[k] = int'((dec >> (8 * (4 - k))) & 40'hFF);
      if ((bytes[0] + bytes[1] + bytes[2] + bytes[3]) % 256 == bytes[4]) begin
        exp_err  = 0;
        exp_hum  = 16'(bytes[0] * 256 + bytes[1]);
        exp_temp = 16'(bytes[2] * 256 + bytes[3]);
      end else begin
        exp_err = 3;
      end
    end

    check_eq({name, "_drive_en_cycles"}, de_high, START_N);
    check_eq({name, "_valid_and_error"}, both_n, 0);
    check_eq({name, "_err_code"}, bus.err_code, exp_err);
    check_eq({name, "_valid_pulses"}, valid_n, (exp_err == 0) ? 1 : 0);
    check_eq({name, "_error_pulses"}, error_n, (exp_err == 0) ? 0 : 1);
    check_eq({name, "_humidity"}, bus.humidity, exp_hum);
    check_eq({name, "_temperature"}, bus.temperature, exp_temp);
    check_eq({name, "_busy_after"}, bus.busy, 0);
    if (no_resp) check_eq({name, "_timeout_latency"}, err_cyc - de_fall_cyc, TMO);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] f;
    logic [7:0]  c;
    bus.start = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(3);

    set_frame(40'h37_00_19_00_50, 4, 14);
    run_read("good");

    set_frame(40'h37_00_19_00_51, 4, 14);
    start_on_pulse = 1;
    run_read("bad_csum");

    set_frame(40'h37_00_19_00_50, 4, 14);
    no_resp = 1;
    run_read("no_resp");

    set_frame(40'h37_00_19_00_50, 4, 14);
    stuck_bit = 12;
    run_read("stuck");

    set_frame(40'h12_34_56_78_14, 4, 14);
    mid_start_bit = 5;
    run_read("mid_start");

    set_frame(40'h12_34_56_78_14, 4, 14);
    reset_bit = 20;
    run_read("mid_reset");

    set_frame(40'h01_02_03_04_0A, 10, 11);
    run_read("thresh_edge");

    for (int t = 0; t < 14; t++) begin
      f[39:8] = $urandom;
      c = 8'(f[39:32] + f[31:24] + f[23:16] + f[15:8]);
      if ($urandom_range(0, 3) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      f[7:0] = c;
      set_frame(f, 4, 14);
      for (int b = 0; b < 40; b++) begin
        hi_len[b] = f[39-b] ? int'($urandom_range(11, 20)) : int'($urandom_range(2, 10));
        lo_len[b] = int'($urandom_range(2, 6));
      end
      resp_low  = int'($urandom_range(3, 10));
      resp_high = int'($urandom_range(3, 10));
      start_on_pulse = bit'($urandom_range(0, 1));
      run_read("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
